// File: rtl/ls_counter_pkg.sv
// Shared definitions for the LS-style cascadable counters: slice width,
// slice-count helper and the control-priority encoding.
package ls_counter_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        CTL_CLR,
        CTL_LOAD,
        CTL_COUNT,
        CTL_HOLD
    } ctl_e;

    function automatic int nslices(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/ls_down_slice.sv
// 4-bit synchronous presettable down-counter slice with ripple-borrow output.
module ls_down_slice
    import ls_counter_pkg::*;
#(
    parameter logic [3:0] RESET_VAL = 4'd0
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] D,
    input  logic       LOAD_n,
    input  logic       ENP,
    input  logic       ENT,
    output logic [3:0] Q,
    output logic       RBO
);

    logic [3:0] q_reg;
    ctl_e       ctl_next;

    always_comb begin
        ctl_next = CTL_HOLD;
        if (CLR)
            ctl_next = CTL_CLR;
        else if (!LOAD_n)
            ctl_next = CTL_LOAD;
        else if (ENP && ENT)
            ctl_next = CTL_COUNT;
    end

    always_ff @(posedge CLK) begin
        case (ctl_next)
            CTL_CLR:   q_reg <= RESET_VAL;
            CTL_LOAD:  q_reg <= D;
            CTL_COUNT: q_reg <= q_reg - 4'd1;
            default:   q_reg <= q_reg;
        endcase
    end

    assign Q   = q_reg;
    // Borrow is purely combinational so the next slice's ENT sees it this cycle.
    assign RBO = ENT && (q_reg == 4'd0);

endmodule

// File: rtl/ls_down_counter.sv
// WIDTH-bit presettable down-counter built from chained 4-bit slices, with a
// sticky underflow flag. Optional auto-reload on wrap: LS_DOWN_AUTO_RELOAD_EN.
module ls_down_counter
    import ls_counter_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD_n,
    input  logic             ENP,
    input  logic             ENT,
    output logic [WIDTH-1:0] Q,
    output logic             RBO,
    output logic             UF
);

    localparam int NS = nslices(WIDTH);

    logic [NS:0]      ent_chain;
    logic [WIDTH-1:0] q_bus;
    logic [WIDTH-1:0] slice_d;
    logic             slice_load_n;
    logic             wrap;
    logic             uf_reg;
    ctl_e             ctl_next;

    assign ent_chain[0] = ENT;
    assign RBO          = ent_chain[NS];
    // An enabled edge while the whole counter reads zero is the underflow edge.
    assign wrap         = ENP && RBO;

`ifdef LS_DOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_reg;

    always_ff @(posedge CLK) begin
        if (CLR)
            reload_reg <= RESET_VAL;
        else if (!LOAD_n)
            reload_reg <= D;
    end

    // Turn the wrap edge into an internal load of the reload value.
    assign slice_load_n = LOAD_n && !wrap;
    assign slice_d      = LOAD_n ? reload_reg : D;
`else
    assign slice_load_n = LOAD_n;
    assign slice_d      = D;
`endif

    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_slice
            ls_down_slice #(
                .RESET_VAL (RESET_VAL[gi*SLICE_W +: SLICE_W])
            ) u_slice (
                .CLK    (CLK),
                .CLR    (CLR),
                .D      (slice_d[gi*SLICE_W +: SLICE_W]),
                .LOAD_n (slice_load_n),
                .ENP    (ENP),
                .ENT    (ent_chain[gi]),
                .Q      (q_bus[gi*SLICE_W +: SLICE_W]),
                .RBO    (ent_chain[gi+1])
            );
        end
    endgenerate

    always_comb begin
        ctl_next = CTL_HOLD;
        if (CLR)
            ctl_next = CTL_CLR;
        else if (!LOAD_n)
            ctl_next = CTL_LOAD;
        else if (ENP && ENT)
            ctl_next = CTL_COUNT;
    end

    always_ff @(posedge CLK) begin
        case (ctl_next)
            CTL_CLR, CTL_LOAD: uf_reg <= 1'b0;
            CTL_COUNT:         uf_reg <= uf_reg || wrap;
            default:           uf_reg <= uf_reg;
        endcase
    end

    assign Q  = q_bus;
    assign UF = uf_reg;

endmodule

// File: tb/tb_ls_down_counter.sv
// Randomized self-checking bench for ls_down_counter (4- and 8-bit instances)
// against an arithmetic reference model.
module tb_ls_down_counter;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] d;
    logic       load_n;
    logic       enp;
    logic       ent;
    logic [3:0] q4;
    logic [7:0] q8;
    logic       rbo4, rbo8, uf4, uf8;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: plain integers
    int mq4 = 0, muf4 = 0, mrl4 = 0;
    int mq8 = 0, muf8 = 0, mrl8 = 0;

    always #5 clk = ~clk;

    ls_down_counter #(.WIDTH(4), .RESET_VAL(4'd0)) dut4 (
        .CLK(clk), .CLR(clr), .D(d[3:0]), .LOAD_n(load_n), .ENP(enp), .ENT(ent),
        .Q(q4), .RBO(rbo4), .UF(uf4)
    );

    ls_down_counter #(.WIDTH(8), .RESET_VAL(8'd0)) dut8 (
        .CLK(clk), .CLR(clr), .D(d), .LOAD_n(load_n), .ENP(enp), .ENT(ent),
        .Q(q8), .RBO(rbo8), .UF(uf8)
    );

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_edge(inout int q, inout int uf, inout int rl, input int width,
                              input int c, input int dv, input int ln, input int p, input int t);
        int modv;
        modv = 1 << width;
        if (c != 0) begin
            q = 0; uf = 0; rl = 0;
        end else if (ln == 0) begin
            q = dv % modv; uf = 0; rl = dv % modv;
        end else if (p != 0 && t != 0) begin
            if (q == 0) begin
`ifdef LS_DOWN_AUTO_RELOAD_EN
                q = rl;
`else
                q = modv - 1;
`endif
                uf = 1;
            end else begin
                q = q - 1;
            end
        end
    endtask

    task automatic step(input logic c, input logic ln, input logic [7:0] dv,
                        input logic p, input logic t);
        @(negedge clk);
        clr = c; load_n = ln; d = dv; enp = p; ent = t;
        @(posedge clk);
        model_edge(mq4, muf4, mrl4, 4, int'(c), int'(dv), int'(ln), int'(p), int'(t));
        model_edge(mq8, muf8, mrl8, 8, int'(c), int'(dv), int'(ln), int'(p), int'(t));
        #1;
        $display("txn clr=%0d load_n=%0d d=%0d enp=%0d ent=%0d -> q4=%0d q8=%0d rbo4=%0d rbo8=%0d uf4=%0d uf8=%0d",
                 c, ln, dv, p, t, q4, q8, rbo4, rbo8, uf4, uf8);
        check("q4",   int'(q4),   mq4);
        check("uf4",  int'(uf4),  muf4);
        check("rbo4", int'(rbo4), (t && mq4 == 0) ? 1 : 0);
        check("q8",   int'(q8),   mq8);
        check("uf8",  int'(uf8),  muf8);
        check("rbo8", int'(rbo8), (t && mq8 == 0) ? 1 : 0);
    endtask

    initial begin
        clr = 1'b1; load_n = 1'b1; d = '0; enp = 1'b0; ent = 1'b1;

        // Reset, then idle with ENP=0
        step(1, 1, 8'd0, 0, 1);
        step(0, 1, 8'd0, 0, 1);
        step(0, 1, 8'd0, 0, 1);

        // Load 5, count down to 0, then wrap
        step(0, 0, 8'd5, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 8'd0, 1, 1);
        step(0, 1, 8'd0, 1, 1);
        step(0, 1, 8'd0, 0, 1);

        // Priority: clear beats load, then load beats count
        step(1, 0, 8'd9, 1, 1);
        step(0, 0, 8'd9, 1, 1);

        // Cascade: 0x10 down through 0x00 and wrap
        step(0, 0, 8'h10, 0, 1);
        for (int i = 0; i < 17; i++) step(0, 1, 8'd0, 1, 1);

        // Enable gating at Q=3
        step(0, 0, 8'd3, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 8'd0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'd0, 0, 1);

        // Load while at zero with counting enabled: load wins, no underflow
        step(0, 0, 8'd0, 0, 1);
        step(0, 0, 8'd7, 1, 1);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            logic rc, rl, rp, rt;
            logic [7:0] rd;
            rc = ($urandom_range(0, 29) == 0);
            rl = ($urandom_range(0, 7) != 0);
            rp = ($urandom_range(0, 3) != 0);
            rt = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            step(rc, rl, rd, rp, rt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ls_down_counter.md
Name: ls_down_counter

Overview:
- Synchronous presettable binary down-counter with ripple-borrow output. It is the counting-down counterpart of the team's 74LS163-style up-counter.
- Used as a programmable divider and timeout timer: load N, count to 0, then flag the borrow.
- Built from cascadable 4-bit slices chained through ENT/RBO, matching the up-counter's cascade scheme.

Parameters:
- WIDTH, 4, counter width in bits; must be a multiple of 4 (one slice per nibble).
- RESET_VAL, 0, value Q takes on CLR.

Ports:
- CLK, input, 1, clock; all state changes on the rising edge.
- CLR, input, 1, synchronous active-high reset; highest priority.
- D, input, WIDTH, parallel load value.
- LOAD_n, input, 1, active-low synchronous parallel load.
- ENP, input, 1, count enable (parallel).
- ENT, input, 1, count enable (trickle); also gates RBO.
- Q, output, WIDTH, counter value (registered).
- RBO, output, 1, ripple borrow out.
- UF, output, 1, sticky underflow flag (registered).

Behaviour:
- Interface: one clock, CLK. Reset CLR is synchronous and active-high. No asynchronous paths.
- Priority at each rising CLK edge, highest first:
  1. CLR=1: Q<=RESET_VAL, UF<=0.
  2. LOAD_n=0: Q<=D, UF<=0. Load ignores ENP/ENT.
  3. ENP=1 and ENT=1: Q<=Q-1 modulo 2^WIDTH.
  4. Otherwise: hold.
- Reset values: Q=RESET_VAL, UF=0. After reset, RBO = ENT && (RESET_VAL==0).
- RBO is combinational: RBO = ENT && (Q==0). It does not depend on ENP or CLK. It goes high in the same cycle Q reaches 0 and feeds the next slice's ENT.
- Wrap-around: counting from Q=0 with ENP=ENT=1 gives Q=2^WIDTH-1 (all ones) and sets UF<=1. UF stays set until CLR or a load.
- Simultaneous events:
  - CLR with LOAD_n=0: clear wins.
  - LOAD_n=0 with Q=0 and count enabled: load wins; UF cleared, not set.
- Clearing mid-count: Q returns to RESET_VAL on the next edge; there is no partial update.
- Latency: Q reflects any load/count/clear one edge after the control is sampled.
- Hold: ENP=0 or ENT=0 freezes Q and UF. ENT=0 also forces RBO=0.
- Cascade: slice k's ENT = ENT && RBO of slices 0..k-1 (ripple). ENP is shared by all slices. The top slice's RBO is the block's RBO.

Optional Feature:
- Macro: LS_DOWN_AUTO_RELOAD_EN.
- Defined:
  - Adds a WIDTH-bit reload register, RELOAD_VAL, loaded from D on every load (LOAD_n=0) and set to RESET_VAL on CLR.
  - Counting from Q=0 with enable sets Q<=RELOAD_VAL instead of all ones, and still sets UF.
  - Gives a divide-by-(N+1) divider without an external load.
- Not defined:
  - No reload register; wrap goes to all ones as above.
  - Ports are identical in both builds.

Decomposition:
- Package ls_counter_pkg:
  - SLICE_W=4.
  - Function nslices(WIDTH)=WIDTH/SLICE_W.
  - Shared enum for control priority (CTL_CLR, CTL_LOAD, CTL_COUNT, CTL_HOLD), also reused by the up-counter.
- Sub-module ls_down_slice:
  - 4-bit slice with ports CLK, CLR, D[3:0], LOAD_n, ENP, ENT, Q[3:0], RBO.
  - Generated nslices(WIDTH) times.
- UF and the optional reload logic live in the top level, not in the slice.

Test Plan:
- Reset: WIDTH=4, CLR=1 for 1 cycle, ENT=1 -> Q=0, UF=0, RBO=1; release CLR, hold ENP=0 -> Q stays 0.
- Load then count: LOAD_n=0 with D=5, then ENP=ENT=1 for 5 edges -> Q goes 5,4,3,2,1,0; RBO=1 only while Q=0.
- Wrap / UF: one further enabled edge from Q=0 -> Q=15, UF=1. Without the macro, Q=15. With LS_DOWN_AUTO_RELOAD_EN, Q=5 (reload value).
- Priority: on the same edge, CLR=1 and LOAD_n=0 with D=9 -> Q=0. Next edge, LOAD_n=0 with D=9 while ENP=ENT=1 -> Q=9, UF=0.
- Cascade: WIDTH=8, load 0x10, count enabled -> Q=0x0F after 1 edge; after 16 edges Q=0x00 and RBO=1; one more edge -> Q=0xFF, UF=1.
- Enable gating: Q=3; ENT=0 with ENP=1 for 4 edges -> Q=3 and RBO=0 throughout. ENP=0, ENT=1 -> Q held at 3.
